vector_sequencer: RTL and testbench

- Parametrised successor to the single-instruction vector decode/sequencing front end.
- Accepts instructions from the APU request interface into an instruction FIFO of depth FIFO_DEPTH.
- Expands each instruction into per-beat micro-ops covering vl elements, LANES elements per beat, with a valid/ready stall handshake toward the datapath.
- Generates per-beat vector register addresses and element counts, then signals completion back to the core.

---
 rtl/vector_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_vector_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_sequencer.sv
// vector_sequencer
//   Vector instruction front end. Instructions offered on the APU request
//   interface are queued in a FIFO of FIFO_DEPTH entries. Each entry is
//   expanded into ceil(vl/LANES) micro-op beats (one beat for single-beat
//   instructions), with per-beat register addresses and active-element
//   counts. A one-cycle apu_rvalid pulse reports completion to the core.
//
// Optional feature (macro VSEQ_BYPASS_EN):
//   When defined, an instruction arriving at an empty FIFO is presented as
//   beat 0 in the same cycle, straight from apu_instr/vl. When undefined,
//   the first uop_valid appears the cycle after the enqueue.
//
// Ports:
//   clk, n_reset          clock, asynchronous active-low reset
//   apu_req / apu_gnt     instruction offer / FIFO not full
//   apu_instr             raw instruction (vs1=[19:15], vs2=[24:20], vd=[11:7])
//   apu_multi, apu_fix_vd pre-decoded multi-beat and reduction flags
//   vl                    vector length, captured at enqueue
//   uop_valid / uop_ready micro-op handshake toward the datapath
//   uop_instr             instruction of the head entry
//   vs1/vs2/vd_addr       per-beat register addresses
//   uop_elems             active elements in the current beat
//   uop_first, uop_last   beat position flags
//   apu_rvalid            completion pulse
//   o_dbg_state           FSM state (0 = IDLE, 1 = ISSUE)
//
// Handshake: a beat transfers on a cycle where uop_valid && uop_ready are
// both high. Once uop_valid is raised it stays high and every uop_* output
// and address is held constant until that transfer happens; uop_valid never
// depends on uop_ready.
module vector_sequencer #(
  parameter int LANES      = 4,
  parameter int VL_W       = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int REG_ADDR_W = 5
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic                         apu_req,
  output logic                         apu_gnt,
  input  logic [31:0]                  apu_instr,
  input  logic                         apu_multi,
  input  logic                         apu_fix_vd,
  input  logic [VL_W-1:0]              vl,
  output logic                         uop_valid,
  input  logic                         uop_ready,
  output logic [31:0]                  uop_instr,
  output logic [REG_ADDR_W-1:0]        vs1_addr,
  output logic [REG_ADDR_W-1:0]        vs2_addr,
  output logic [REG_ADDR_W-1:0]        vd_addr,
  output logic [$clog2(LANES+1)-1:0]   uop_elems,
  output logic                         uop_first,
  output logic                         uop_last,
  output logic                         apu_rvalid,
  output logic                         o_dbg_state
);

  localparam int LG = $clog2(LANES);          // LANES is a power of two
  localparam int EW = $clog2(LANES + 1);
  localparam int SW = VL_W + LG + 1;          // holds vl + LANES - 1
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  // FIFO storage
  logic [31:0]     r_instr [FIFO_DEPTH];
  logic            r_multi [FIFO_DEPTH];
  logic            r_fix   [FIFO_DEPTH];
  logic [VL_W-1:0] r_vl    [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_full;

  state_t          r_state, w_state_next;
  logic [SW-1:0]   r_beat;
  logic            r_rvalid;

  logic            w_push, w_bypass, w_active;
  logic [31:0]     w_h_instr;
  logic            w_h_multi, w_h_fix;
  logic [VL_W-1:0] w_h_vl;
  logic [SW-1:0]   w_nbeats, w_rem;
  logic            w_zero, w_last_beat, w_uop_valid, w_accept, w_done;
  logic            w_wr_en, w_rd_en;
  logic [CW-1:0]   w_count_next;
  logic [EW-1:0]   w_elems;
  logic [REG_ADDR_W-1:0] w_beat_a, w_src1, w_src2, w_dst;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign apu_gnt = !r_full;
  assign w_push  = apu_req && apu_gnt;

`ifdef VSEQ_BYPASS_EN
  // IDLE means the FIFO holds nothing, so the incoming request is the head.
  assign w_bypass = w_push && (r_state == S_IDLE);
`else
  assign w_bypass = 1'b0;
`endif

  // Head entry: either the FIFO read slot or the bypassed request.
  assign w_h_instr = w_bypass ? apu_instr  : r_instr[r_rd_ptr];
  assign w_h_multi = w_bypass ? apu_multi  : r_multi[r_rd_ptr];
  assign w_h_fix   = w_bypass ? apu_fix_vd : r_fix[r_rd_ptr];
  assign w_h_vl    = w_bypass ? vl         : r_vl[r_rd_ptr];
  assign w_active  = (r_state == S_ISSUE) || w_bypass;

  // Beat count: ceil(vl/LANES) for multi-beat, otherwise one beat.
  assign w_nbeats    = w_h_multi ? ((SW'(w_h_vl) + SW'(LANES - 1)) >> LG) : SW'(1);
  assign w_zero      = w_active && (w_nbeats == '0);
  assign w_last_beat = (r_beat == w_nbeats - SW'(1));
  assign w_uop_valid = w_active && !w_zero;
  assign w_accept    = w_uop_valid && uop_ready;
  // A zero-beat entry retires in the cycle it reaches the head.
  assign w_done      = (w_accept && w_last_beat) || w_zero;

  // A bypassed request that also completes this cycle never occupies a slot.
  assign w_wr_en      = w_push && !(w_bypass && w_done);
  assign w_rd_en      = w_done && !w_bypass;
  assign w_count_next = r_count + CW'(w_wr_en) - CW'(w_rd_en);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_instr[i] <= '0;
        r_multi[i] <= 1'b0;
        r_fix[i]   <= 1'b0;
        r_vl[i]    <= '0;
      end
    end else if (w_wr_en) begin
      r_instr[r_wr_ptr] <= apu_instr;
      r_multi[r_wr_ptr] <= apu_multi;
      r_fix[r_wr_ptr]   <= apu_fix_vd;
      r_vl[r_wr_ptr]    <= vl;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_beat   <= '0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd_en) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count  <= w_count_next;
      r_full   <= (w_count_next == CW'(FIFO_DEPTH));
      r_rvalid <= w_done;
      if (w_done)        r_beat <= '0;
      else if (w_accept) r_beat <= r_beat + SW'(1);
    end
  end

  // FSM: ISSUE exactly while the FIFO holds at least one entry.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_count_next != '0) w_state_next = S_ISSUE;
      S_ISSUE: if (w_count_next == '0) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Element count: full beats except the tail of a multi-beat instruction.
  always_comb begin
    w_rem = SW'(w_h_vl) - (r_beat << LG);
    if (!w_h_multi)       w_elems = EW'(1);
    else if (w_last_beat) w_elems = EW'(w_rem);
    else                  w_elems = EW'(LANES);
  end

  assign w_beat_a = REG_ADDR_W'(r_beat);
  assign w_src1   = REG_ADDR_W'(w_h_instr[19:15]);
  assign w_src2   = REG_ADDR_W'(w_h_instr[24:20]);
  assign w_dst    = REG_ADDR_W'(w_h_instr[11:7]);

  // Outputs read as zero whenever no beat is presented.
  assign uop_valid   = w_uop_valid;
  assign uop_instr   = w_uop_valid ? w_h_instr : '0;
  assign vs1_addr    = !w_uop_valid ? '0 : (w_h_fix ? w_src1 : w_src1 + w_beat_a);
  assign vs2_addr    = !w_uop_valid ? '0 : w_src2 + w_beat_a;
  assign vd_addr     = !w_uop_valid ? '0 : (w_h_fix ? w_dst : w_dst + w_beat_a);
  assign uop_elems   = w_uop_valid ? w_elems : '0;
  assign uop_first   = w_uop_valid && (r_beat == '0);
  assign uop_last    = w_uop_valid && w_last_beat;
  assign apu_rvalid  = r_rvalid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vector_sequencer.sv
// Testbench for vector_sequencer (LANES=4, VL_W=5, FIFO_DEPTH=2, REG_ADDR_W=5).
// A queue-based reference model compares every cycle; a vector table and a
// few hand sequences cover the documented corner cases.
module tb_vector_sequencer;
  localparam int LANES = 4, VL_W = 5, FIFO_DEPTH = 2, RA = 5;

  logic clk, n_reset;
  logic apu_req, apu_gnt, apu_multi, apu_fix_vd;
  logic [31:0] apu_instr, uop_instr;
  logic [VL_W-1:0] vl;
  logic uop_valid, uop_ready, uop_first, uop_last, apu_rvalid, dbg_state;
  logic [RA-1:0] vs1_addr, vs2_addr, vd_addr;
  logic [$clog2(LANES+1)-1:0] uop_elems;

  vector_sequencer #(.LANES(LANES), .VL_W(VL_W), .FIFO_DEPTH(FIFO_DEPTH), .REG_ADDR_W(RA)) dut (
    .clk(clk), .n_reset(n_reset), .apu_req(apu_req), .apu_gnt(apu_gnt),
    .apu_instr(apu_instr), .apu_multi(apu_multi), .apu_fix_vd(apu_fix_vd), .vl(vl),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_instr(uop_instr),
    .vs1_addr(vs1_addr), .vs2_addr(vs2_addr), .vd_addr(vd_addr), .uop_elems(uop_elems),
    .uop_first(uop_first), .uop_last(uop_last), .apu_rvalid(apu_rvalid),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    bit          multi;
    bit          fix;
    int          vlv;
  } ins_t;

  ins_t mq[$];          // instructions the DUT currently holds, head first
  int   m_beat = 0;     // beats of the head already transferred
  bit   m_rv_next = 0;  // completion expected on the next cycle
  int   done_cnt = 0;   // apu_rvalid pulses seen
  int   lg_vd[$], lg_vs1[$], lg_vs2[$], lg_el[$];

  function automatic int beats_of(ins_t h);
    if (!h.multi) return 1;
    return (h.vlv + LANES - 1) / LANES;
  endfunction

  always @(negedge clk) begin
    ins_t h, cur;
    int n, b, e_vs1, e_vs2, e_vd, e_el, src1, src2, dst;
    bit eg, do_push;
    if (!n_reset) begin
      chk("rst_valid", uop_valid, 0);
      chk("rst_gnt", apu_gnt, 1);
      chk("rst_rvalid", apu_rvalid, 0);
      chk("rst_outs", {uop_instr, vs1_addr, vs2_addr, vd_addr, uop_elems, uop_first, uop_last}, 0);
      mq.delete();
      m_beat = 0;
      m_rv_next = 0;
    end else begin
      if (apu_rvalid) done_cnt++;
      eg = (mq.size() < FIFO_DEPTH);
      chk("gnt", apu_gnt, eg);
      chk("rvalid", apu_rvalid, m_rv_next);
      m_rv_next = 0;
      cur.instr = apu_instr;
      cur.multi = apu_multi;
      cur.fix   = apu_fix_vd;
      cur.vlv   = int'(vl);
      do_push = apu_req && eg;
`ifdef VSEQ_BYPASS_EN
      if (do_push && mq.size() == 0) begin
        mq.push_back(cur);
        do_push = 0;
      end
`endif
      if (mq.size() > 0) begin
        h = mq[0];
        n = beats_of(h);
        if (n == 0) begin
          chk("zero_valid", uop_valid, 0);
          void'(mq.pop_front());
          m_rv_next = 1;
        end else begin
          b    = m_beat;
          src1 = int'(h.instr[19:15]);
          src2 = int'(h.instr[24:20]);
          dst  = int'(h.instr[11:7]);
          e_vs1 = h.fix ? src1 : (src1 + b) % 32;
          e_vs2 = (src2 + b) % 32;
          e_vd  = h.fix ? dst : (dst + b) % 32;
          if (!h.multi)       e_el = 1;
          else if (b == n-1)  e_el = h.vlv - b * LANES;
          else                e_el = LANES;
          chk("valid", uop_valid, 1);
          chk("instr", uop_instr, h.instr);
          chk("addrs", {vs1_addr, vs2_addr, vd_addr}, {RA'(e_vs1), RA'(e_vs2), RA'(e_vd)});
          chk("elems", uop_elems, e_el);
          chk("first_last", {uop_first, uop_last}, {b == 0, b == n-1});
          if (uop_ready) begin
            lg_vd.push_back(int'(vd_addr));
            lg_vs1.push_back(int'(vs1_addr));
            lg_vs2.push_back(int'(vs2_addr));
            lg_el.push_back(int'(uop_elems));
            m_beat++;
            if (m_beat == n) begin
              void'(mq.pop_front());
              m_beat = 0;
              m_rv_next = 1;
            end
          end
        end
      end else begin
        chk("idle_valid", uop_valid, 0);
      end
      if (do_push) mq.push_back(cur);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] mk_instr(int s1, int s2, int d);
    logic [4:0] a, c, e;
    a = s1[4:0];
    c = s2[4:0];
    e = d[4:0];
    return {7'($urandom), c, a, 3'($urandom), e, 7'($urandom)};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic enqueue(input logic [31:0] ins, input bit multi, input bit fix, input int vlv);
    int budget = 60;
    apu_req = 1'b1;
    apu_instr = ins;
    apu_multi = multi;
    apu_fix_vd = fix;
    vl = VL_W'(vlv);
    @(negedge clk);
    while (!apu_gnt && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("enq_wait", budget > 0, 1);
    @(posedge clk);
    #1;
    apu_req = 1'b0;
    // Later vl/instr changes must not affect the queued entry.
    vl = VL_W'($urandom);
    apu_instr = $urandom;
  endtask

  task automatic wait_done(input int target);
    int budget = 0;
    while (done_cnt < target && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    chk("done_wait", done_cnt >= target, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int budget = 0;
    while ((mq.size() != 0 || apu_rvalid) && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    chk("idle_wait", mq.size() == 0, 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int vs1, vs2, vd;
    bit multi, fix;
    int vlv;
    int exp_n, exp_vd0, exp_vd_l, exp_vs1_l, exp_vs2_l, exp_el_l;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [63:0] snap;
    int start, d0;
    bit pushed;

    n_reset = 1'b0;
    apu_req = 1'b0;
    apu_instr = '0;
    apu_multi = 1'b0;
    apu_fix_vd = 1'b0;
    vl = '0;
    uop_ready = 1'b1;

    tbl[0] = '{2, 8, 16, 1, 0, 10, 3, 16, 18, 4, 10, 2};
    tbl[1] = '{3, 4, 1, 1, 1, 7, 2, 1, 1, 3, 5, 3};
    tbl[2] = '{0, 0, 31, 1, 0, 8, 2, 31, 0, 1, 1, 4};
    tbl[3] = '{5, 6, 7, 0, 0, 20, 1, 7, 7, 5, 6, 1};
    tbl[4] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{30, 29, 28, 1, 0, 31, 8, 28, 3, 5, 4, 3};
    tbl[6] = '{1, 2, 3, 1, 0, 4, 1, 3, 3, 1, 2, 4};
    tbl[7] = '{9, 10, 11, 1, 1, 1, 1, 11, 11, 9, 10, 1};

    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 8; t++) begin
      start = lg_vd.size();
      d0 = done_cnt;
      enqueue(mk_instr(tbl[t].vs1, tbl[t].vs2, tbl[t].vd), tbl[t].multi, tbl[t].fix, tbl[t].vlv);
      wait_done(d0 + 1);
      chk("tbl_nbeats", lg_vd.size() - start, tbl[t].exp_n);
      if (lg_vd.size() - start == tbl[t].exp_n && tbl[t].exp_n > 0) begin
        chk("tbl_vd_first", lg_vd[start], tbl[t].exp_vd0);
        chk("tbl_vd_last", lg_vd[$], tbl[t].exp_vd_l);
        chk("tbl_vs1_last", lg_vs1[$], tbl[t].exp_vs1_l);
        chk("tbl_vs2_last", lg_vs2[$], tbl[t].exp_vs2_l);
        chk("tbl_elems_last", lg_el[$], tbl[t].exp_el_l);
      end
    end
    wait_idle();

    // Zero-beat instruction: completion timing relative to enqueue.
    enqueue(mk_instr(1, 2, 3), 1'b1, 1'b0, 0);
    @(negedge clk);
`ifdef VSEQ_BYPASS_EN
    chk("zb_rv_c1", {apu_rvalid, uop_valid}, 2'b10);
    @(negedge clk);
    chk("zb_rv_c2", apu_rvalid, 0);
`else
    chk("zb_rv_c1", {apu_rvalid, uop_valid}, 2'b00);
    @(negedge clk);
    chk("zb_rv_c2", {apu_rvalid, uop_valid}, 2'b10);
    @(negedge clk);
    chk("zb_rv_c3", apu_rvalid, 0);
`endif
    wait_idle();

    // FIFO full, stall stability, in-order drain with no bubble.
    uop_ready = 1'b0;
    fork
      begin
        enqueue(mk_instr(4, 5, 6), 1'b1, 1'b0, 8);
        enqueue(mk_instr(7, 8, 9), 1'b0, 1'b0, 3);
        enqueue(mk_instr(10, 11, 12), 1'b1, 1'b0, 5);
      end
      begin
        repeat (3) @(negedge clk);
        chk("full_gnt", apu_gnt, 0);
        snap = {uop_valid, uop_instr, vs1_addr, vs2_addr, vd_addr, uop_elems, uop_first, uop_last};
        repeat (3) begin
          @(negedge clk);
          chk("stall_hold", {uop_valid, uop_instr, vs1_addr, vs2_addr, vd_addr, uop_elems, uop_first, uop_last}, snap);
        end
        @(posedge clk);
        #1;
        uop_ready = 1'b1;
        repeat (5) begin
          @(negedge clk);
          chk("drain_no_bubble", uop_valid, 1);
        end
      end
    join
    wait_idle();

    // Reset during beat 2 of 3.
    d0 = done_cnt;
    enqueue(mk_instr(0, 0, 0), 1'b1, 1'b0, 12);
    start = 0;
    @(negedge clk);
    while (!(uop_valid && !uop_first && !uop_last) && start < 20) begin
      @(negedge clk);
      start++;
    end
    chk("rst_beat2_seen", start < 20, 1);
    #2;
    n_reset = 1'b0;
    #1;
    chk("rst_now_outs", {uop_valid, apu_rvalid, uop_first, uop_last, vd_addr, vs1_addr, vs2_addr, uop_elems}, 0);
    chk("rst_now_gnt", apu_gnt, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_no_rvalid", done_cnt, d0);
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    repeat (500) begin
      @(negedge clk);
      pushed = apu_req && apu_gnt;
      @(posedge clk);
      #1;
      uop_ready = ($urandom_range(0, 3) != 0);
      if (pushed || !apu_req) begin
        if ($urandom_range(0, 2) != 0) begin
          apu_req = 1'b1;
          apu_instr = $urandom;
          apu_multi = ($urandom_range(0, 3) != 0);
          apu_fix_vd = ($urandom_range(0, 3) == 0);
          vl = ($urandom_range(0, 5) == 0) ? '0 : VL_W'($urandom_range(0, 31));
        end else begin
          apu_req = 1'b0;
          vl = VL_W'($urandom);
        end
      end
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    apu_req = 1'b0;
    uop_ready = 1'b1;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
